// File: rtl/main_ram.sv
// Word-addressed backing memory with fixed access latency, placed behind the
// direct-mapped cache. It accepts one level-held request and reports busy on response.
module main_ram #(
  parameter int SIZE      = 4096,
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [31:0] address,
  input  logic        mode,
  output logic [31:0] out,
  output logic        response
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state;
  logic [7:0]             counter;
  logic [ADDR_BITS-1:0]   cap_addr;
  logic [31:0]            cap_data;
  logic                   cap_mode;
  logic                   prev_valid;

  logic [31:0] mem [0:SIZE-1] = '{default: '0};

  logic [ADDR_BITS-1:0] addr_idx;
  logic                 is_new;
  logic                 done;
  logic                 unused_addr_hi;

  assign addr_idx       = address[ADDR_BITS-1:0];
  assign unused_addr_hi = ^address[31:ADDR_BITS];

  // A changed request has priority over completion, so an in-flight
  // operation is discarded before it can touch memory.
  always_comb begin
    is_new = !prev_valid || (addr_idx != cap_addr) ||
             (data != cap_data) || (mode != cap_mode);
    done   = !rst && !is_new && (state == BUSY) && (counter == 8'd1);
  end

  always_ff @(posedge clk) begin
    if (done && cap_mode)
      mem[cap_addr] <= cap_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      response   <= 1'b0;
      out        <= '0;
      counter    <= '0;
      cap_addr   <= '0;
      cap_data   <= '0;
      cap_mode   <= 1'b0;
      prev_valid <= 1'b0;
    end else if (is_new) begin
      cap_addr   <= addr_idx;
      cap_data   <= data;
      cap_mode   <= mode;
      prev_valid <= 1'b1;
      state      <= BUSY;
      counter    <= 8'(LATENCY);
      response   <= 1'b1;
    end else if (state == BUSY) begin
      if (done) begin
        out      <= cap_mode ? cap_data : mem[cap_addr];
        counter  <= '0;
        response <= 1'b0;
        state    <= IDLE;
      end else begin
        counter  <= counter - 8'd1;
      end
    end else begin
      response <= 1'b0;
    end
  end

endmodule

// File: tb/tb_main_ram.sv
// Self-checking bench for main_ram: expected read data is kept in a scoreboard
// queue and compared when response falls.
module tb_main_ram;

  logic        clk;
  logic        rst;
  logic [31:0] data;
  logic [31:0] address;
  logic        mode;
  logic [31:0] out;
  logic        response;

  int checks;
  int failures;
  logic [31:0] exp_q [$];
  logic [31:0] model [int];

  main_ram #(.SIZE(4096), .ADDR_BITS(12), .LATENCY(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .address  (address),
    .mode     (mode),
    .out      (out),
    .response (response)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int idx;
    idx = int'(a % 32'd4096);
    if (model.exists(idx)) return model[idx];
    return 32'h0;
  endfunction

  // Pushes the model's expectation, presents the request and waits (bounded)
  // for response to fall; returns the number of busy cycles seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] d, input logic m,
                        output int busy);
    if (m) begin
      model[int'(a % 32'd4096)] = d;
      exp_q.push_back(d);
    end else begin
      exp_q.push_back(model_rd(a));
    end
    address = a;
    data    = d;
    mode    = m;
    busy    = 0;
    step();
    while (response === 1'b1 && busy < 50) begin
      busy++;
      step();
    end
  endtask

  task automatic pop_check(input string name, input int busy);
    logic [31:0] e;
    checks++;
    if (busy !== 4) begin
      failures++;
      $display("FAIL %s_latency: busy cycles %0d expected 4", name, busy);
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s_scoreboard: queue empty, out=%h", name, out);
    end else begin
      e = exp_q.pop_front();
      if (out !== e) begin
        failures++;
        $display("FAIL %s_data: out=%h expected %h", name, out, e);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; address = '0; data = '0; mode = 1'b0;
    step();
    step();
    checks++;
    if (response !== 1'b0 || out !== 32'h0) begin
      failures++;
      $display("FAIL reset: response=%b out=%h expected 0 / 00000000", response, out);
    end
    rst = 1'b0;
  endtask

  task automatic test_read_zero();
    int b;
    run_op(32'd0, 32'h0, 1'b0, b);
    pop_check("read_zero", b);
  endtask

  task automatic test_write_read();
    int b;
    run_op(32'd5, 32'hDEADBEEF, 1'b1, b);
    pop_check("write5", b);
    run_op(32'd5, 32'h0, 1'b0, b);
    pop_check("read5", b);
  endtask

  task automatic test_wrap();
    int b;
    // Data differs from the previous request so this counts as new; reads ignore it.
    run_op(32'd4101, 32'h000000A5, 1'b0, b);
    pop_check("wrap4101", b);
  endtask

  task automatic test_hold();
    int b;
    int extra;
    run_op(32'd5, 32'h0, 1'b0, b);
    pop_check("hold_first", b);
    extra = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (response !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL hold_no_restart: busy cycles %0d expected 0", extra);
    end
  endtask

  task automatic test_abort();
    int b;
    address = 32'd7; data = 32'h11111111; mode = 1'b1;
    step();
    step();
    checks++;
    if (response !== 1'b1) begin
      failures++;
      $display("FAIL abort_busy: response=%b expected 1", response);
    end
    run_op(32'd5, 32'h0, 1'b0, b);
    pop_check("abort_read5", b);
    run_op(32'd7, 32'h0, 1'b0, b);
    pop_check("abort_read7", b);
  endtask

  task automatic test_reset_mid();
    int b;
    address = 32'd9; data = 32'hCAFEF00D; mode = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (response !== 1'b0 || out !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid: response=%b out=%h expected 0 / 00000000", response, out);
    end
    rst = 1'b0;
    run_op(32'd9, 32'hCAFEF00D, 1'b1, b);
    pop_check("reissue_write9", b);
    run_op(32'd9, 32'h0, 1'b0, b);
    pop_check("read9", b);
  endtask

  task automatic test_back_to_back();
    int b;
    for (int i = 0; i < 4; i++) begin
      run_op(32'(100 + i), 32'h1000 * 32'(i + 1) + 32'h5A, 1'b1, b);
      pop_check("b2b_write", b);
    end
    for (int i = 3; i >= 0; i--) begin
      run_op(32'(4096 * 2 + 100 + i), 32'h0, 1'b0, b);
      pop_check("b2b_read", b);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_read_zero();
    test_write_read();
    test_wrap();
    test_hold();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
